// File: rtl/tlb_inv_walker.sv
// INVTLB engine: walks every TLB entry in index order and rewrites each entry
// selected by the invalidate op with e=0, owning the TLB write port while busy.
module tlb_inv_walker #(
  parameter int TLBNUM           = 16,
  parameter int TLBNUM_IDX_WIDTH = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [4:0]                  req_op,
  input  logic [9:0]                  req_asid,
  input  logic [18:0]                 req_vppn,
  output logic                        busy,
  output logic                        done,
  output logic                        op_err,
  output logic [TLBNUM_IDX_WIDTH-1:0] r_index,
  input  logic                        r_e,
  input  logic [18:0]                 r_vppn,
  input  logic [5:0]                  r_ps,
  input  logic [9:0]                  r_asid,
  input  logic                        r_g,
  input  logic [19:0]                 r_ppn0,
  input  logic [1:0]                  r_plv0,
  input  logic [1:0]                  r_mat0,
  input  logic                        r_d0,
  input  logic                        r_v0,
  input  logic [19:0]                 r_ppn1,
  input  logic [1:0]                  r_plv1,
  input  logic [1:0]                  r_mat1,
  input  logic                        r_d1,
  input  logic                        r_v1,
  output logic                        we,
  output logic [TLBNUM_IDX_WIDTH-1:0] w_index,
  output logic                        w_e,
  output logic [18:0]                 w_vppn,
  output logic [5:0]                  w_ps,
  output logic [9:0]                  w_asid,
  output logic                        w_g,
  output logic [19:0]                 w_ppn0,
  output logic [1:0]                  w_plv0,
  output logic [1:0]                  w_mat0,
  output logic                        w_d0,
  output logic                        w_v0,
  output logic [19:0]                 w_ppn1,
  output logic [1:0]                  w_plv1,
  output logic [1:0]                  w_mat1,
  output logic                        w_d1,
  output logic                        w_v1
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_ERR   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [TLBNUM_IDX_WIDTH-1:0] LAST = TLBNUM_IDX_WIDTH'(TLBNUM - 1);

  logic [2:0]                  state;
  logic [TLBNUM_IDX_WIDTH-1:0] idx;
  logic [4:0]                  op_q;
  logic [9:0]                  asid_q;
  logic [18:0]                 vppn_q;

  logic [5:0]  sh;
  logic [18:0] mask;
  logic        gm;
  logic        vm;
  logic        sel;
  logic        hit;

  // Incoming d/v bits are deliberately discarded: invalidated entries get d/v cleared.
  logic unused_dv;
  assign unused_dv = ^{r_d0, r_v0, r_d1, r_v1};

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN) || (state == S_ERR);
  assign op_err    = (state == S_ERR);
  assign r_index   = (state == S_SCAN) ? idx : '0;

  always_comb begin
    sh = '0;
    if (r_ps > 6'd12) sh = r_ps - 6'd12;
    if (sh > 6'd19) sh = 6'd19;
    mask = '0;
    for (int unsigned i = 0; i < 19; i++) mask[i] = (i >= 32'(sh));
    vm  = ((r_vppn ^ vppn_q) & mask) == '0;
    gm  = !r_g && (r_asid == asid_q);
    sel = 1'b0;
    case (op_q)
      5'd0, 5'd1: sel = 1'b1;
      5'd2:       sel = r_g;
      5'd3:       sel = !r_g;
      5'd4:       sel = gm;
      5'd5:       sel = gm && vm;
      5'd6:       sel = (r_g || (r_asid == asid_q)) && vm;
      default:    sel = 1'b0;
    endcase
    hit = r_e && sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      we      <= 1'b0;
      w_index <= '0;
      w_e     <= 1'b0;
      w_vppn  <= '0;
      w_ps    <= '0;
      w_asid  <= '0;
      w_g     <= 1'b0;
      w_ppn0  <= '0;
      w_plv0  <= '0;
      w_mat0  <= '0;
      w_d0    <= 1'b0;
      w_v0    <= 1'b0;
      w_ppn1  <= '0;
      w_plv1  <= '0;
      w_mat1  <= '0;
      w_d1    <= 1'b0;
      w_v1    <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            asid_q <= req_asid;
            vppn_q <= req_vppn;
            idx    <= '0;
            state  <= (req_op <= 5'd6) ? S_SCAN : S_ERR;
          end
        end
        S_SCAN: begin
          if (hit) begin
            // Write data is captured here so we/w_* are clean registered outputs in WRITE.
            state   <= S_WRITE;
            we      <= 1'b1;
            w_index <= idx;
            w_e     <= 1'b0;
            w_vppn  <= r_vppn;
            w_ps    <= r_ps;
            w_asid  <= r_asid;
            w_g     <= r_g;
            w_ppn0  <= r_ppn0;
            w_plv0  <= r_plv0;
            w_mat0  <= r_mat0;
            w_d0    <= 1'b0;
            w_v0    <= 1'b0;
            w_ppn1  <= r_ppn1;
            w_plv1  <= r_plv1;
            w_mat1  <= r_mat1;
            w_d1    <= 1'b0;
            w_v1    <= 1'b0;
          end else if (idx == LAST) begin
            state <= S_FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WRITE: begin
          if (idx == LAST) begin
            state <= S_FIN;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_SCAN;
          end
        end
        S_ERR, S_FIN: state <= S_IDLE;
        default:      state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_inv_walker.sv
// Bench for tlb_inv_walker: a behavioural 16-entry TLB array answers the read
// port, absorbs writes, and expected writes/latency come from the INVTLB rules.
module tb_tlb_inv_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [9:0]  req_asid;
  logic [18:0] req_vppn;
  logic        busy, done, op_err;
  logic [3:0]  r_index;
  logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
  logic        we;
  logic [3:0]  w_index;
  logic        w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;

  logic        t_e    [16];
  logic [18:0] t_vppn [16];
  logic [5:0]  t_ps   [16];
  logic [9:0]  t_asid [16];
  logic        t_g    [16];
  logic [19:0] t_ppn0 [16];
  logic [19:0] t_ppn1 [16];
  logic [1:0]  t_plv0 [16];
  logic [1:0]  t_mat0 [16];
  logic [1:0]  t_plv1 [16];
  logic [1:0]  t_mat1 [16];
  logic [3:0]  t_dv   [16];

  int vectors = 0;
  int miscompares = 0;
  int exp_w[$];

  always #5 clk = ~clk;

  tlb_inv_walker #(.TLBNUM(16), .TLBNUM_IDX_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_asid(req_asid), .req_vppn(req_vppn),
    .busy(busy), .done(done), .op_err(op_err), .r_index(r_index),
    .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0),
    .w_d0(w_d0), .w_v0(w_v0), .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1),
    .w_d1(w_d1), .w_v1(w_v1)
  );

  always_comb begin
    r_e    = t_e[r_index];
    r_vppn = t_vppn[r_index];
    r_ps   = t_ps[r_index];
    r_asid = t_asid[r_index];
    r_g    = t_g[r_index];
    r_ppn0 = t_ppn0[r_index];
    r_plv0 = t_plv0[r_index];
    r_mat0 = t_mat0[r_index];
    r_ppn1 = t_ppn1[r_index];
    r_plv1 = t_plv1[r_index];
    r_mat1 = t_mat1[r_index];
    {r_d0, r_v0, r_d1, r_v1} = t_dv[r_index];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // TLB write port: compare against the expected write sequence, then commit.
  always @(negedge clk) begin
    if (!reset && we) begin
      if (exp_w.size() == 0) begin
        check("spurious_we", 64'(w_index), 64'hFFFF);
      end else begin
        int i;
        i = exp_w.pop_front();
        check("w_index", 64'(w_index), 64'(i));
        check("w_e", 64'(w_e), 64'd0);
        check("w_dv", 64'({w_d0, w_v0, w_d1, w_v1}), 64'd0);
        check("w_tag", 64'({w_vppn, w_ps, w_asid, w_g}),
              64'({t_vppn[i], t_ps[i], t_asid[i], t_g[i]}));
        check("w_page", {8'd0, w_ppn0, w_plv0, w_mat0, w_ppn1, w_plv1, w_mat1},
              {8'd0, t_ppn0[i], t_plv0[i], t_mat0[i], t_ppn1[i], t_plv1[i], t_mat1[i]});
      end
      t_e[w_index]    = w_e;
      t_vppn[w_index] = w_vppn;
      t_ps[w_index]   = w_ps;
      t_asid[w_index] = w_asid;
      t_g[w_index]    = w_g;
      t_ppn0[w_index] = w_ppn0;
      t_plv0[w_index] = w_plv0;
      t_mat0[w_index] = w_mat0;
      t_ppn1[w_index] = w_ppn1;
      t_plv1[w_index] = w_plv1;
      t_mat1[w_index] = w_mat1;
      t_dv[w_index]   = {w_d0, w_v0, w_d1, w_v1};
    end
  end

  function automatic bit model_hit(int i, int op, int asid, int vppn);
    int sh;
    bit gm, vm;
    if (!t_e[i]) return 1'b0;
    sh = (int'(t_ps[i]) > 12) ? int'(t_ps[i]) - 12 : 0;
    if (sh > 19) sh = 19;
    vm = (int'(t_vppn[i]) >> sh) == (vppn >> sh);
    gm = !t_g[i] && (int'(t_asid[i]) == asid);
    case (op)
      0, 1:    return 1'b1;
      2:       return t_g[i];
      3:       return !t_g[i];
      4:       return gm;
      5:       return gm && vm;
      6:       return (t_g[i] || int'(t_asid[i]) == asid) && vm;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] valid_mask();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = t_e[i];
    return m;
  endfunction

  task automatic set_entry(int i, bit e, bit g, int asid, int vppn, int ps);
    t_e[i]    = e;
    t_g[i]    = g;
    t_asid[i] = 10'(asid);
    t_vppn[i] = 19'(vppn);
    t_ps[i]   = 6'(ps);
    t_ppn0[i] = 20'($urandom);
    t_ppn1[i] = 20'($urandom);
    t_plv0[i] = 2'($urandom);
    t_mat0[i] = 2'($urandom);
    t_plv1[i] = 2'($urandom);
    t_mat1[i] = 2'($urandom);
    t_dv[i]   = 4'($urandom) | 4'b0101;
  endtask

  function automatic int rand_vppn();
    int low;
    low = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
    return (int'($urandom_range(0, 3)) << 10) | low;
  endfunction

  task automatic fill_random(bit all_valid);
    int ps_tab[8] = '{12, 12, 5, 13, 21, 22, 28, 40};
    for (int i = 0; i < 16; i++)
      set_entry(i, all_valid || ($urandom_range(0, 3) != 0), $urandom_range(0, 3) == 0,
                $urandom_range(1, 3), rand_vppn(), ps_tab[$urandom_range(0, 7)]);
  endtask

  task automatic run_req(input string tag, input int op, input int asid, input int vppn);
    int n, cyc;
    bit seen;
    logic [15:0] exp_valid;
    exp_w.delete();
    exp_valid = valid_mask();
    n = 0;
    for (int i = 0; i < 16; i++)
      if (model_hit(i, op, asid, vppn)) begin
        exp_w.push_back(i);
        exp_valid[i] = 1'b0;
        n++;
      end
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 5'(op);
    req_asid  = 10'(asid);
    req_vppn  = 19'(vppn);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      req_op   = 5'($urandom);
      req_asid = 10'($urandom);
      req_vppn = 19'($urandom);
    end
    check({tag, "_latency"}, 64'(cyc), (op <= 6) ? 64'(16 + n + 1) : 64'd1);
    check({tag, "_op_err"}, 64'(op_err), (op <= 6) ? 64'd0 : 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    check({tag, "_ready_done"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    check({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    check({tag, "_idle_after"}, 64'({busy, done, we}), 64'd0);
    check({tag, "_writes_left"}, 64'(exp_w.size()), 64'd0);
    check({tag, "_valid"}, 64'(valid_mask()), 64'(exp_valid));
  endtask

  initial begin
    int cyc, dones;
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_asid = '0;
    req_vppn = '0;
    fill_random(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_flags", 64'({busy, done, op_err, we}), 64'd0);
    check("rst_r_index", 64'(r_index), 64'd0);
    check("rst_w", 64'({w_index, w_e, w_vppn, w_asid, w_g, w_d0, w_v0}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    fill_random(1'b1);
    run_req("op0_all", 0, 0, 0);

    fill_random(1'b1);
    for (int i = 0; i < 16; i++) t_g[i] = (i == 3 || i == 7);
    run_req("op2_global", 2, 0, 0);

    for (int i = 0; i < 16; i++) set_entry(i, 1'b1, 1'b0, 'h20, 'h40000, 12);
    set_entry(5, 1'b1, 1'b0, 'h12, 'h40000, 12);
    set_entry(9, 1'b1, 1'b0, 'h12, 'h40001, 21);
    set_entry(6, 1'b1, 1'b0, 'h13, 'h40000, 12);
    run_req("op5_mask", 5, 'h12, 'h40000);
    check("op5_e9_cleared", 64'(t_e[9]), 64'd0);

    run_req("op7_err", 7, 0, 0);

    // Reset in the middle of a full walk, while entry 4 is being read.
    fill_random(1'b1);
    exp_w.delete();
    for (int i = 0; i < 16; i++) exp_w.push_back(i);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 5'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    dones = 0;
    while (!(busy && r_index == 4'd4) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
    end
    check("midrst_reach_idx4", 64'(r_index), 64'd4);
    reset = 1'b1;
    #1;
    check("midrst_idle", 64'({busy, done, op_err, we}), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_r_index", 64'(r_index), 64'd0);
    check("midrst_writes", 64'(exp_w.size()), 64'd12);
    @(negedge clk);
    reset = 1'b0;
    exp_w.delete();
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    check("midrst_valid", 64'(valid_mask()), 64'hFFF0);

    // Back-to-back: req_valid held through the done cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 5'd7;
    check("b2b_ready0", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("b2b_done1", 64'({done, op_err, req_ready}), 64'b110);
    @(negedge clk);
    check("b2b_idle", 64'({busy, done, req_ready}), 64'b001);
    @(negedge clk);
    check("b2b_done2", 64'({busy, done, op_err}), 64'b111);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_end", 64'({busy, req_ready}), 64'b01);

    for (int k = 0; k < 12; k++) begin
      int op;
      fill_random(1'b0);
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 31)) : int'($urandom_range(0, 6));
      run_req($sformatf("rand%0d_op%0d", k, op), op, $urandom_range(1, 3), rand_vppn());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
